home_automation_rr_ctrl: RTL and testbench

- Parametrised successor to the home-automation state controller. Serves N_SENSORS door, fire and window sensor channels plus heater and cooler climate channels.
- Per-sensor debounce, temperature hysteresis, minimum dwell per granted channel, and round-robin arbitration over all channels.
- Drives one-hot actuator outputs and a channel-code display. Sits between the raw sensor/temperature inputs and the actuator/display drivers.

---
 rtl/home_automation_rr_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_home_automation_rr_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/home_automation_rr_ctrl.sv
// Home-automation controller: debounced sensor channels plus hysteretic
// heater/cooler requests, served round-robin with a minimum dwell per grant.
// Channel order: 0..N_SENSORS-1 = sensors, N_SENSORS = heater, N_SENSORS+1 = cooler.
// The outputs are registered and are computed from the next state, so a grant
// is visible on the same edge that the state and the current channel change.
module home_automation_rr_ctrl #(
    parameter int N_SENSORS  = 4,
    parameter int TEMP_W     = 6,
    parameter int T_LOW      = 10,
    parameter int T_HIGH     = 21,
    parameter int HYST       = 2,
    parameter int DEB_CYCLES = 3,
    parameter int MIN_DWELL  = 4,
    localparam int IDX_W     = $clog2(N_SENSORS + 3)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_SENSORS-1:0]   sensors,
    input  logic [TEMP_W-1:0]      temp,
    output logic [N_SENSORS+1:0]   output_signals,
    output logic [IDX_W-1:0]       display,
    output logic                   busy,
    output logic                   dbg_state
);

    localparam int N_CH  = N_SENSORS + 2;
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int DW_W  = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;

    localparam logic [DEB_W-1:0] DEB_ONE = 1;
    localparam logic [DW_W-1:0]  DW_ONE  = 1;
    localparam logic [IDX_W-1:0] IDX_ONE = 1;

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    logic [N_SENSORS-1:0] r_req;
    logic [DEB_W-1:0]     r_deb_cnt [N_SENSORS];
    logic                 r_heat;
    logic                 r_cool;
    state_t               r_state;
    logic [IDX_W-1:0]     r_cur;
    logic [DW_W-1:0]      r_dwell;
    logic [N_CH-1:0]      r_out;
    logic [IDX_W-1:0]     r_disp;
    logic                 r_busy;

    logic [31:0]          w_temp_ext;
    logic [N_CH-1:0]      w_req_vec;
    logic                 w_cur_req;
    logic                 w_low_found;
    logic [IDX_W-1:0]     w_low_idx;
    logic                 w_rr_found;
    logic [IDX_W-1:0]     w_rr_idx;
    state_t               w_next_state;
    logic [IDX_W-1:0]     w_next_cur;
    logic [DW_W-1:0]      w_next_dwell;
    logic [N_CH-1:0]      w_next_out;
    logic [IDX_W-1:0]     w_next_disp;
    logic                 w_next_busy;

    assign w_temp_ext = 32'(temp);

    // Per-sensor debounce: count consecutive samples disagreeing with the
    // debounced level, adopt the raw level once the run reaches DEB_CYCLES.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req <= '0;
            for (int i = 0; i < N_SENSORS; i++) r_deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_SENSORS; i++) begin
                if (sensors[i] == r_req[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (32'(r_deb_cnt[i]) == DEB_CYCLES - 1) begin
                    r_req[i]     <= sensors[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DEB_ONE;
                end
            end
        end
    end

    // Climate requests with a hysteresis band; inside the band they hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_heat <= 1'b0;
            r_cool <= 1'b0;
        end else begin
            if (w_temp_ext < T_LOW)               r_heat <= 1'b1;
            else if (w_temp_ext >= T_LOW + HYST)  r_heat <= 1'b0;
            if (w_temp_ext > T_HIGH)              r_cool <= 1'b1;
            else if (w_temp_ext <= T_HIGH - HYST) r_cool <= 1'b0;
        end
    end

    // Arbitration: lowest-index pick from idle, round-robin search after cur
    // (cur itself examined last), then next state, dwell and output values.
    always_comb begin
        int cand;
        cand         = 0;
        w_req_vec    = {r_cool, r_heat, r_req};
        w_cur_req    = 1'b0;
        w_low_found  = 1'b0;
        w_low_idx    = '0;
        w_rr_found   = 1'b0;
        w_rr_idx     = '0;
        for (int j = 0; j < N_CH; j++) begin
            if (int'(r_cur) == j) w_cur_req = w_req_vec[j];
            if (!w_low_found && w_req_vec[j]) begin
                w_low_found = 1'b1;
                w_low_idx   = IDX_W'(j);
            end
        end
        for (int k = 1; k <= N_CH; k++) begin
            cand = int'(r_cur) + k;
            if (cand >= N_CH) cand = cand - N_CH;
            for (int j = 0; j < N_CH; j++) begin
                if (!w_rr_found && cand == j && w_req_vec[j]) begin
                    w_rr_found = 1'b1;
                    w_rr_idx   = IDX_W'(j);
                end
            end
        end

        w_next_state = r_state;
        w_next_cur   = r_cur;
        w_next_dwell = r_dwell;
        case (r_state)
            ST_IDLE: begin
                if (w_low_found) begin
                    w_next_state = ST_ACTIVE;
                    w_next_cur   = w_low_idx;
                    w_next_dwell = '0;
                end
            end
            ST_ACTIVE: begin
                if (w_cur_req && (32'(r_dwell) < MIN_DWELL - 1)) begin
                    w_next_dwell = r_dwell + DW_ONE;
                end else if (w_rr_found) begin
                    w_next_cur   = w_rr_idx;
                    w_next_dwell = '0;
                end else begin
                    w_next_state = ST_IDLE;
                    w_next_dwell = '0;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_dwell = '0;
            end
        endcase

        w_next_out  = '0;
        w_next_disp = '0;
        w_next_busy = 1'b0;
        if (w_next_state == ST_ACTIVE) begin
            w_next_busy = 1'b1;
            w_next_disp = w_next_cur + IDX_ONE;
            for (int j = 0; j < N_CH; j++) begin
                if (int'(w_next_cur) == j) w_next_out[j] = 1'b1;
            end
        end
    end

    // State, current channel, dwell and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cur   <= '0;
            r_dwell <= '0;
            r_out   <= '0;
            r_disp  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cur   <= w_next_cur;
            r_dwell <= w_next_dwell;
            r_out   <= w_next_out;
            r_disp  <= w_next_disp;
            r_busy  <= w_next_busy;
        end
    end

    assign output_signals = r_out;
    assign display        = r_disp;
    assign busy           = r_busy;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_home_automation_rr_ctrl.sv
// Bench for home_automation_rr_ctrl: directed table, hand-written corner
// sequences and randomized stimulus against a behavioural reference model.
module tb_home_automation_rr_ctrl;

    localparam int NS        = 4;
    localparam int TW        = 6;
    localparam int T_LOW     = 10;
    localparam int T_HIGH    = 21;
    localparam int HYST      = 2;
    localparam int DEB       = 3;
    localparam int MIN_DWELL = 4;
    localparam int NCH       = NS + 2;
    localparam int IDX_W     = $clog2(NS + 3);
    localparam int EW        = NCH + IDX_W + 1;

    logic             clk;
    logic             rst;
    logic [NS-1:0]    sensors;
    logic [TW-1:0]    temp;
    logic [NCH-1:0]   output_signals;
    logic [IDX_W-1:0] display;
    logic             busy;
    logic             dbg_state;

    home_automation_rr_ctrl #(
        .N_SENSORS(NS), .TEMP_W(TW), .T_LOW(T_LOW), .T_HIGH(T_HIGH),
        .HYST(HYST), .DEB_CYCLES(DEB), .MIN_DWELL(MIN_DWELL)
    ) dut (
        .clk(clk), .rst(rst), .sensors(sensors), .temp(temp),
        .output_signals(output_signals), .display(display),
        .busy(busy), .dbg_state(dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];

    // Reference model state
    int m_win [NS][DEB];
    int m_req [NS];
    int m_heat, m_cool, m_active, m_cur, m_held;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NS; i++) begin
            m_req[i] = 0;
            for (int d = 0; d < DEB; d++) m_win[i][d] = 0;
        end
        m_heat = 0; m_cool = 0; m_active = 0; m_cur = 0; m_held = 0;
    endtask

    // One clock edge of the model, given the inputs sampled at that edge.
    // Arbitration sees the request set as it stood before this edge.
    task automatic m_clock(input logic [NS-1:0] s, input int t);
        int r [NCH];
        int found, nxt, c, flip;
        for (int i = 0; i < NS; i++) r[i] = m_req[i];
        r[NS]     = m_heat;
        r[NS + 1] = m_cool;
        if (m_active == 0) begin
            found = 0; nxt = 0;
            for (int k = NCH - 1; k >= 0; k--) if (r[k] != 0) begin nxt = k; found = 1; end
            if (found != 0) begin m_active = 1; m_cur = nxt; m_held = 1; end
        end else if (r[m_cur] != 0 && m_held < MIN_DWELL) begin
            m_held++;
        end else begin
            found = 0; nxt = 0;
            for (int k = 1; k <= NCH; k++) begin
                c = (m_cur + k) % NCH;
                if (found == 0 && r[c] != 0) begin found = 1; nxt = c; end
            end
            if (found != 0) begin m_cur = nxt; m_held = 1; end
            else m_active = 0;
        end
        // A sensor follows its raw level once the last DEB samples all disagree.
        for (int i = 0; i < NS; i++) begin
            for (int d = DEB - 1; d >= 1; d--) m_win[i][d] = m_win[i][d - 1];
            m_win[i][0] = int'(s[i]);
            flip = 1;
            for (int d = 0; d < DEB; d++) if (m_win[i][d] == m_req[i]) flip = 0;
            if (flip != 0) m_req[i] = int'(s[i]);
        end
        if (t < T_LOW) m_heat = 1;
        else if (t >= T_LOW + HYST) m_heat = 0;
        if (t > T_HIGH) m_cool = 1;
        else if (t <= T_HIGH - HYST) m_cool = 0;
    endtask

    function automatic logic [EW-1:0] m_expect();
        logic [NCH-1:0]   o;
        logic [IDX_W-1:0] d;
        logic             b;
        o = '0; d = '0; b = 1'b0;
        if (m_active != 0) begin
            o[m_cur] = 1'b1;
            d = IDX_W'(m_cur + 1);
            b = 1'b1;
        end
        return {o, d, b};
    endfunction

    // Driver: apply inputs at a falling edge, clock once, check on next falling edge.
    task automatic step(input logic [NS-1:0] s, input int t);
        logic [EW-1:0] e;
        sensors = s;
        temp    = TW'(t);
        @(posedge clk);
        m_clock(s, t);
        exp_q.push_back(m_expect());
        @(negedge clk);
        e = exp_q.pop_front();
        chk("sb_out", int'(output_signals), int'(e[EW-1 -: NCH]));
        chk("sb_disp", int'(display), int'(e[IDX_W:1]));
        chk("sb_busy", int'(busy), int'(e[0]));
        chk("dbg_state", int'(dbg_state), int'(e[0]));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sensors = '0;
        temp = TW'(15);
        #1;
        chk("rst_out", int'(output_signals), 0);
        chk("rst_disp", int'(display), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        m_reset();
        exp_q.delete();
    endtask

    typedef struct {
        logic [NS-1:0]  s;
        int             t;
        logic [NCH-1:0] out;
        int             disp;
        logic           bsy;
    } vec_t;

    vec_t tbl [20];

    initial begin
        logic [NS-1:0] rs;
        int rt;

        // Hysteresis, then debounce glitch and debounced grant, from reset.
        tbl[0]  = '{4'b0000,  9, 6'b000000, 0, 1'b0};
        tbl[1]  = '{4'b0000,  9, 6'b010000, 5, 1'b1};
        tbl[2]  = '{4'b0000, 11, 6'b010000, 5, 1'b1};
        tbl[3]  = '{4'b0000, 12, 6'b010000, 5, 1'b1};
        tbl[4]  = '{4'b0000, 12, 6'b000000, 0, 1'b0};
        tbl[5]  = '{4'b0000, 22, 6'b000000, 0, 1'b0};
        tbl[6]  = '{4'b0000, 22, 6'b100000, 6, 1'b1};
        tbl[7]  = '{4'b0000, 20, 6'b100000, 6, 1'b1};
        tbl[8]  = '{4'b0000, 20, 6'b100000, 6, 1'b1};
        tbl[9]  = '{4'b0000, 20, 6'b100000, 6, 1'b1};
        tbl[10] = '{4'b0000, 20, 6'b100000, 6, 1'b1};
        tbl[11] = '{4'b0000, 19, 6'b100000, 6, 1'b1};
        tbl[12] = '{4'b0000, 19, 6'b000000, 0, 1'b0};
        tbl[13] = '{4'b0001, 15, 6'b000000, 0, 1'b0};
        tbl[14] = '{4'b0001, 15, 6'b000000, 0, 1'b0};
        tbl[15] = '{4'b0000, 15, 6'b000000, 0, 1'b0};
        tbl[16] = '{4'b0001, 15, 6'b000000, 0, 1'b0};
        tbl[17] = '{4'b0001, 15, 6'b000000, 0, 1'b0};
        tbl[18] = '{4'b0001, 15, 6'b000000, 0, 1'b0};
        tbl[19] = '{4'b0001, 15, 6'b000001, 1, 1'b1};

        do_reset();
        for (int r = 0; r < 20; r++) begin
            step(tbl[r].s, tbl[r].t);
            chk("tbl_out", int'(output_signals), int'(tbl[r].out));
            chk("tbl_disp", int'(display), tbl[r].disp);
            chk("tbl_busy", int'(busy), int'(tbl[r].bsy));
        end

        // Reset mid-grant: channel 0 is granted now; outputs must clear at once.
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_out", int'(output_signals), 0);
        chk("midrst_disp", int'(display), 0);
        chk("midrst_busy", int'(busy), 0);
        m_reset();
        exp_q.delete();
        sensors = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step(4'b0000, 15);
            chk("post_rst_idle", int'(busy), 0);
        end

        // Round robin between two sensors with a 4-cycle dwell.
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            step(4'b0011, 15);
            chk("rr_disp", int'(display), (e < 4) ? 0 : ((e - 4) / 4) % 2 + 1);
        end

        // Early release: channel 2 granted while its debounced drop lands.
        do_reset();
        for (int e = 1; e <= 14; e++) begin
            step((e <= 5) ? 4'b0101 : 4'b0001, 15);
            chk("early_disp", int'(display), (e < 4) ? 0 : (e <= 7) ? 1 : (e == 8) ? 3 : 1);
        end

        // Full load: four sensors plus heater rotate, cooler never granted.
        do_reset();
        for (int e = 1; e <= 33; e++) begin
            step(4'b1111, (e <= 4) ? 15 : 5);
            chk("full_disp", int'(display), (e < 4) ? 0 : ((e - 4) / 4) % 5 + 1);
            chk("full_no_cool", int'(output_signals[NS + 1]), 0);
        end

        // Randomized stimulus against the model.
        do_reset();
        rs = '0;
        rt = 15;
        for (int n = 0; n < 1500; n++) begin
            if (n == 750) begin
                do_reset();
                rs = '0;
            end
            for (int i = 0; i < NS; i++) if ($urandom_range(0, 5) == 0) rs[i] = ~rs[i];
            if ($urandom_range(0, 7) == 0) rt = int'($urandom_range(0, 30));
            step(rs, rt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
